// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter sequencer with start/run/halt control and retired-instruction counter
module fetch_unit #(
    parameter int          pc_width   = 10,
    parameter int unsigned start_addr = 0,
    parameter int          cnt_width  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 jump,
    input  logic                 branch_taken,
    input  logic [7:0]           offset,
    input  logic                 done,
    output logic [pc_width-1:0]  pc,
    output logic                 running,
    output logic                 halted,
    output logic [cnt_width-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [pc_width-1:0] start_pc = pc_width'(start_addr);

    state_t                state_q, state_d;
    logic [pc_width-1:0]   pc_q, pc_d;
    logic [cnt_width-1:0]  cnt_q, cnt_d;
    logic [pc_width-1:0]   offset_ext;
    logic [cnt_width-1:0]  cnt_sat;

    assign offset_ext = pc_width'($signed(offset));
    assign cnt_sat    = (cnt_q == '1) ? cnt_q : cnt_q + cnt_width'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= start_pc;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every RUN cycle retires one instruction, including the done instruction itself.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                pc_d = start_pc;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_sat;
                if (done) begin
                    state_d = HALT;
                end else if (jump || branch_taken) begin
                    pc_d = pc_q + offset_ext;
                end else begin
                    pc_d = pc_q + pc_width'(1);
                end
            end
            HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = start_pc;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = start_pc;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc          = pc_q;
        cycle_count = cnt_q;
        running     = (state_q == RUN);
        halted      = (state_q == HALT);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, start, jump, branch_taken, done;
    logic [7:0]  offset;
    logic [9:0]  pc;
    logic        running, halted;
    logic [15:0] cycle_count;

    logic        reset_s, start_s;
    logic        zero_s = 1'b0;
    logic [7:0]  zero8_s = 8'h00;
    logic [9:0]  pc_s;
    logic        running_s, halted_s;
    logic [3:0]  cycle_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .start(start), .jump(jump),
        .branch_taken(branch_taken), .offset(offset), .done(done),
        .pc(pc), .running(running), .halted(halted), .cycle_count(cycle_count)
    );

    fetch_unit #(.pc_width(10), .start_addr(0), .cnt_width(4)) dut_small (
        .clk(clk), .reset(reset_s), .start(start_s), .jump(zero_s),
        .branch_taken(zero_s), .offset(zero8_s), .done(zero_s),
        .pc(pc_s), .running(running_s), .halted(halted_s), .cycle_count(cycle_count_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; reset_s = 1'b1; start = 1'b1; start_s = 1'b1;
        jump = 1'b1; branch_taken = 1'b0; done = 1'b0; offset = 8'h10;
        step();
        step();
        reset = 1'b0; reset_s = 1'b0; start = 1'b0; start_s = 1'b0; jump = 1'b0;
        checks++; if (pc !== 10'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", pc); end
        checks++; if (running !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", running, halted); end
        checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cycle_count); end
        jump = 1'b1; offset = 8'h22;
        step();
        jump = 1'b0;
        checks++; if (pc !== 10'd0 || running !== 1'b0) begin errors++; $display("FAIL idle_ignore pc=%0d run=%b exp pc=0 run=0", pc, running); end
    endtask

    task automatic test_sequential();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (pc !== 10'd0 || running !== 1'b1 || cycle_count !== 16'd0) begin errors++; $display("FAIL start pc=%0d run=%b cnt=%0d exp 0 1 0", pc, running, cycle_count); end
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++; if (pc !== 10'(i)) begin errors++; $display("FAIL seq_pc got=%0d exp=%0d", pc, i); end
        end
        checks++; if (cycle_count !== 16'd5 || running !== 1'b1) begin errors++; $display("FAIL seq_cnt cnt=%0d run=%b exp 5 1", cycle_count, running); end
    endtask

    task automatic test_jump();
        logic [7:0]  offs   [10] = '{8'h0F, 8'hFB, 8'hF4, 8'hF0, 8'h05, 8'h02, 8'h00, 8'h05, 8'h00, 8'h07};
        logic [1:0]  kind   [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd0, 2'd1};
        logic [9:0]  exp_pc [10] = '{10'd20, 10'd15, 10'd3, 10'd1011, 10'd1016, 10'd1018, 10'd1018, 10'd1023, 10'd0, 10'd7};
        for (int i = 0; i < 10; i++) begin
            jump = kind[i][0]; branch_taken = kind[i][1]; offset = offs[i];
            step();
            checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL jump_%0d pc got=%0d exp=%0d", i, pc, exp_pc[i]); end
        end
        jump = 1'b1; done = 1'b1; offset = 8'h10;
        step();
        jump = 1'b0; done = 1'b0; branch_taken = 1'b0;
        checks++; if (pc !== 10'd7 || halted !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL done_prio pc=%0d halt=%b run=%b exp 7 1 0", pc, halted, running); end
        checks++; if (cycle_count !== 16'd16) begin errors++; $display("FAIL done_cnt got=%0d exp=16", cycle_count); end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 10; i++) begin
            jump = i[0]; branch_taken = ~i[0]; done = i[1]; offset = 8'h33;
            step();
        end
        jump = 1'b0; branch_taken = 1'b0; done = 1'b0;
        checks++; if (pc !== 10'd7 || cycle_count !== 16'd16 || halted !== 1'b1) begin errors++; $display("FAIL halt_frozen pc=%0d cnt=%0d halt=%b exp 7 16 1", pc, cycle_count, halted); end
        start = 1'b1; jump = 1'b1; offset = 8'h04;
        step();
        start = 1'b0; jump = 1'b0;
        checks++; if (pc !== 10'd0 || cycle_count !== 16'd0 || running !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL restart pc=%0d cnt=%0d run=%b halt=%b exp 0 0 1 0", pc, cycle_count, running, halted); end
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        step(); step(); step();
        start = 1'b0;
        checks++; if (pc !== 10'd3 || cycle_count !== 16'd3) begin errors++; $display("FAIL start_in_run pc=%0d cnt=%0d exp 3 3", pc, cycle_count); end
    endtask

    task automatic test_reset_mid_run();
        jump = 1'b1; offset = 8'h10; reset = 1'b1;
        step();
        reset = 1'b0; jump = 1'b0;
        checks++; if (pc !== 10'd0 || cycle_count !== 16'd0 || running !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL mid_reset pc=%0d cnt=%0d run=%b halt=%b exp 0 0 0 0", pc, cycle_count, running, halted); end
        start = 1'b1; reset = 1'b1;
        step();
        start = 1'b0; reset = 1'b0;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_over_start run=%b exp 0", running); end
    endtask

    task automatic test_saturation();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        for (int i = 0; i < 15; i++) step();
        checks++; if (cycle_count_s !== 4'd15) begin errors++; $display("FAIL sat_reach got=%0d exp=15", cycle_count_s); end
        for (int i = 0; i < 5; i++) step();
        checks++; if (cycle_count_s !== 4'd15 || pc_s !== 10'd20) begin errors++; $display("FAIL sat_hold cnt=%0d pc=%0d exp 15 20", cycle_count_s, pc_s); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_halt();
        test_start_ignored();
        test_reset_mid_run();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
